// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the 6502 stack sequencer
package stack_pkg;

  typedef enum logic {PUSH = 1'b0, PULL = 1'b1} stack_op_t;

  typedef enum logic [1:0] {REG_A, REG_X, REG_Y, REG_P} stack_reg_t;

  typedef enum logic [1:0] {IDLE, MEM, WR_REG, WR_SP} stack_state_t;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

endpackage

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - moves A/X/Y/P between the register file and the stack page
module stack_sequencer
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [1:0]  cmd_reg,
  input  logic        cmd_wide,
  input  logic [15:0] a_in,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] sp_in,
  input  logic [7:0]  p_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        load_accumulator,
  output logic        load_x,
  output logic        load_y,
  output logic        load_p,
  output logic        load_sp,
  output logic [15:0] data_out,
  output logic        done
);

  stack_state_t state_q, state_d;
  stack_op_t    op_q, op_d;
  stack_reg_t   reg_q, reg_d;
  logic         wide_q, wide_d;
  logic         idx_q, idx_d;
  logic [15:0]  src_q, src_d;
  logic [15:0]  data_q, data_d;
  logic [7:0]   sp_hi_q, sp_hi_d;
  logic [7:0]   sp_work_q, sp_work_d;
  logic         last_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= PUSH;
      reg_q     <= REG_A;
      wide_q    <= 1'b0;
      idx_q     <= 1'b0;
      src_q     <= '0;
      data_q    <= '0;
      sp_hi_q   <= '0;
      sp_work_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      reg_q     <= reg_d;
      wide_q    <= wide_d;
      idx_q     <= idx_d;
      src_q     <= src_d;
      data_q    <= data_d;
      sp_hi_q   <= sp_hi_d;
      sp_work_q <= sp_work_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    reg_d     = reg_q;
    wide_d    = wide_q;
    idx_d     = idx_q;
    src_d     = src_q;
    data_d    = data_q;
    sp_hi_d   = sp_hi_q;
    sp_work_d = sp_work_q;
    last_byte = !wide_q || idx_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = stack_op_t'(cmd_op);
          reg_d   = stack_reg_t'(cmd_reg);
          wide_d  = cmd_wide && (stack_reg_t'(cmd_reg) != REG_P);
          idx_d   = 1'b0;
          data_d  = '0;
          sp_hi_d = sp_in[15:8];
          case (stack_reg_t'(cmd_reg))
            REG_A:   src_d = a_in;
            REG_X:   src_d = x_in;
            REG_Y:   src_d = y_in;
            default: src_d = {8'h00, p_in};
          endcase
          // Pull pre-increments, so the first read address is already sp+1.
          sp_work_d = cmd_op ? sp_in[7:0] + 8'd1 : sp_in[7:0];
          state_d   = MEM;
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (op_q == PUSH) begin
            sp_work_d = sp_work_q - 8'd1;
          end else begin
            if (idx_q) data_d[15:8] = mem_rdata;
            else       data_d       = {8'h00, mem_rdata};
            if (!last_byte) sp_work_d = sp_work_q + 8'd1;
          end
          if (last_byte) state_d = (op_q == PUSH) ? WR_SP : WR_REG;
          else           idx_d   = 1'b1;
        end
      end
      WR_REG:  state_d = WR_SP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready        = (state_q == IDLE);
    mem_req          = (state_q == MEM);
    mem_we           = (state_q == MEM) && (op_q == PUSH);
    mem_addr         = (state_q == MEM) ? {STACK_PAGE, sp_work_q} : 16'h0000;
    mem_wdata        = 8'h00;
    load_accumulator = 1'b0;
    load_x           = 1'b0;
    load_y           = 1'b0;
    load_p           = 1'b0;
    load_sp          = 1'b0;
    data_out         = 16'h0000;
    done             = 1'b0;
    if (mem_we) mem_wdata = (wide_q && !idx_q) ? src_q[15:8] : src_q[7:0];
    if (state_q == WR_REG) begin
      data_out = data_q;
      case (reg_q)
        REG_A:   load_accumulator = 1'b1;
        REG_X:   load_x           = 1'b1;
        REG_Y:   load_y           = 1'b1;
        default: load_p           = 1'b1;
      endcase
    end
    if (state_q == WR_SP) begin
      load_sp  = 1'b1;
      data_out = {sp_hi_q, sp_work_q};
      done     = 1'b1;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - scoreboard bench for stack_sequencer
module tb_stack_sequencer;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } mem_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] data;
  } str_t;

  localparam logic [2:0] K_A = 3'd0, K_X = 3'd1, K_Y = 3'd2, K_P = 3'd3, K_SP = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_reg = 2'd0;
  logic        cmd_wide = 1'b0;
  logic [15:0] a_in = 16'h0, x_in = 16'h0, y_in = 16'h0, sp_in = 16'h0;
  logic [7:0]  p_in = 8'h0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        load_accumulator, load_x, load_y, load_p, load_sp;
  logic [15:0] data_out;
  logic        done;

  int errors = 0;
  int checks = 0;

  mem_t exp_mem[$];
  str_t exp_str[$];
  int   wait_q[$];
  logic [7:0] mem_model [256];

  stack_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_wide(cmd_wide),
    .a_in(a_in), .x_in(x_in), .y_in(y_in), .sp_in(sp_in), .p_in(p_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .load_accumulator(load_accumulator), .load_x(load_x), .load_y(load_y),
    .load_p(load_p), .load_sp(load_sp), .data_out(data_out), .done(done)
  );

  always #5 clk = ~clk;

  // Bus responder and scoreboard consumer, evaluated away from the active edge.
  logic        in_byte = 1'b0;
  int          wait_cnt = 0;
  int          cur_wait = 0;
  int          n_str;
  logic [2:0]  obs_kind;
  logic        hold_we;
  logic [15:0] hold_addr;
  logic [7:0]  hold_wdata;
  mem_t        em;
  str_t        es;

  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack  = 1'b0;
      in_byte  = 1'b0;
      wait_cnt = 0;
    end else begin
      n_str = int'(load_accumulator) + int'(load_x) + int'(load_y) + int'(load_p) + int'(load_sp);
      if (n_str != 0) begin
        checks++;
        obs_kind = load_accumulator ? K_A : load_x ? K_X : load_y ? K_Y : load_p ? K_P : K_SP;
        if (n_str > 1 || exp_str.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got kind=%0d data=%h strobes=%0d, required none", obs_kind, data_out, n_str);
        end else begin
          es = exp_str.pop_front();
          if (obs_kind !== es.kind || data_out !== es.data) begin
            errors++;
            $display("FAIL strobe: got kind=%0d data=%h, required kind=%0d data=%h", obs_kind, data_out, es.kind, es.data);
          end
        end
      end
      if (mem_req) begin
        if (!in_byte) begin
          in_byte    = 1'b1;
          wait_cnt   = 0;
          cur_wait   = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
          hold_we    = mem_we;
          hold_addr  = mem_addr;
          hold_wdata = mem_wdata;
        end else begin
          checks++;
          if (mem_we !== hold_we || mem_addr !== hold_addr || mem_wdata !== hold_wdata) begin
            errors++;
            $display("FAIL bus_stable: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, hold_we, hold_addr, hold_wdata);
          end
        end
        if (wait_cnt < cur_wait) begin
          mem_ack = 1'b0;
          wait_cnt++;
        end else begin
          mem_ack = 1'b1;
          in_byte = 1'b0;
          checks++;
          if (exp_mem.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: got we=%b addr=%h wdata=%h, required no access", mem_we, mem_addr, mem_wdata);
          end else begin
            em = exp_mem.pop_front();
            if (mem_we !== em.we || mem_addr !== em.addr || (em.we && mem_wdata !== em.data)) begin
              errors++;
              $display("FAIL mem_access: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, em.we, em.addr, em.data);
            end
          end
          if (mem_we) mem_model[mem_addr[7:0]] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr[7:0]];
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  task automatic do_cmd(input logic op, input logic [1:0] r, input logic w,
                        output int lat, output logic req1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_wide = w;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    req1 = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req1 = mem_req;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, done, load_accumulator, load_x, load_y, load_p, load_sp} !== 8'h00 ||
        mem_addr !== 16'h0 || mem_wdata !== 8'h0 || data_out !== 16'h0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got req=%b we=%b done=%b addr=%h wdata=%h data=%h ready=%b, required all 0 and ready=1",
               mem_req, mem_we, done, mem_addr, mem_wdata, data_out, cmd_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_narrow_push;
    int lat; logic req1;
    a_in = 16'h1234; sp_in = 16'h01FF;
    exp_mem.push_back(mem_t'{1'b1, 16'h01FF, 8'h34});
    exp_str.push_back(str_t'{K_SP, 16'h01FE});
    do_cmd(1'b0, 2'd0, 1'b0, lat, req1);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL pha_latency: got %0d, required 2", lat); end
    checks++;
    if (req1 !== 1'b1) begin errors++; $display("FAIL pha_req_rise: got %b, required 1", req1); end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL pha_ready_after_done: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_wide_push;
    int lat; logic req1;
    x_in = 16'hBEEF; sp_in = 16'h0110;
    exp_mem.push_back(mem_t'{1'b1, 16'h0110, 8'hBE});
    exp_mem.push_back(mem_t'{1'b1, 16'h010F, 8'hEF});
    exp_str.push_back(str_t'{K_SP, 16'h010E});
    do_cmd(1'b0, 2'd1, 1'b1, lat, req1);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL phx_latency: got %0d, required 3", lat); end
  endtask

  task automatic test_wide_pull;
    int lat; logic req1;
    sp_in = 16'h01FD;
    mem_model[8'hFE] = 8'h78; mem_model[8'hFF] = 8'h56;
    exp_mem.push_back(mem_t'{1'b0, 16'h01FE, 8'h00});
    exp_mem.push_back(mem_t'{1'b0, 16'h01FF, 8'h00});
    exp_str.push_back(str_t'{K_Y, 16'h5678});
    exp_str.push_back(str_t'{K_SP, 16'h01FF});
    do_cmd(1'b1, 2'd2, 1'b1, lat, req1);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL ply_latency: got %0d, required 4", lat); end
  endtask

  task automatic test_wrap;
    int lat; logic req1;
    x_in = 16'h00C3; sp_in = 16'h2300;
    exp_mem.push_back(mem_t'{1'b1, 16'h0100, 8'hC3});
    exp_str.push_back(str_t'{K_SP, 16'h23FF});
    do_cmd(1'b0, 2'd1, 1'b0, lat, req1);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wrap_push_latency: got %0d, required 2", lat); end
    sp_in = 16'h01FF;
    mem_model[8'h00] = 8'hA5;
    exp_mem.push_back(mem_t'{1'b0, 16'h0100, 8'h00});
    exp_str.push_back(str_t'{K_P, 16'h00A5});
    exp_str.push_back(str_t'{K_SP, 16'h0100});
    do_cmd(1'b1, 2'd3, 1'b1, lat, req1);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL plp_latency: got %0d, required 3", lat); end
  endtask

  task automatic test_wait_states;
    int lat; logic req1;
    sp_in = 16'h0140;
    mem_model[8'h41] = 8'h11; mem_model[8'h42] = 8'h22;
    wait_q.push_back(3);
    exp_mem.push_back(mem_t'{1'b0, 16'h0141, 8'h00});
    exp_mem.push_back(mem_t'{1'b0, 16'h0142, 8'h00});
    exp_str.push_back(str_t'{K_A, 16'h2211});
    exp_str.push_back(str_t'{K_SP, 16'h0142});
    do_cmd(1'b1, 2'd0, 1'b1, lat, req1);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL wait_latency: got %0d, required 7", lat); end
  endtask

  task automatic test_snapshot_ignore;
    int lat;
    a_in = 16'h00AB; sp_in = 16'h0130;
    exp_mem.push_back(mem_t'{1'b1, 16'h0130, 8'hAB});
    exp_str.push_back(str_t'{K_SP, 16'h012F});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_reg = 2'd0; cmd_wide = 1'b0;
    @(posedge clk);
    #1 cmd_op = 1'b1; a_in = 16'h00CD; sp_in = 16'h0299;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    cmd_valid = 1'b0;
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL snapshot_latency: got %0d, required 2", lat); end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ignore_valid: got ready=%b req=%b, required ready=1 req=0", cmd_ready, mem_req);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic req1;
    y_in = 16'h9A3C; sp_in = 16'h0160;
    exp_mem.push_back(mem_t'{1'b1, 16'h0160, 8'h9A});
    exp_mem.push_back(mem_t'{1'b1, 16'h015F, 8'h3C});
    exp_str.push_back(str_t'{K_SP, 16'h015E});
    do_cmd(1'b0, 2'd2, 1'b1, lat, req1);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL b2b_push_latency: got %0d, required 3", lat); end
    sp_in = 16'h015E; y_in = 16'h0000;
    exp_mem.push_back(mem_t'{1'b0, 16'h015F, 8'h00});
    exp_mem.push_back(mem_t'{1'b0, 16'h0160, 8'h00});
    exp_str.push_back(str_t'{K_Y, 16'h9A3C});
    exp_str.push_back(str_t'{K_SP, 16'h0160});
    do_cmd(1'b1, 2'd2, 1'b1, lat, req1);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL b2b_pull_latency: got %0d, required 4", lat); end
  endtask

  task automatic test_reset_mid_command;
    int lat; logic req1;
    x_in = 16'hCAFE; sp_in = 16'h0180;
    mem_model[8'h80] = 8'h00; mem_model[8'h7F] = 8'h00;
    wait_q.push_back(0); wait_q.push_back(3);
    exp_mem.push_back(mem_t'{1'b1, 16'h0180, 8'hCA});
    exp_mem.push_back(mem_t'{1'b1, 16'h017F, 8'hFE});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_reg = 2'd1; cmd_wide = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, done, load_accumulator, load_x, load_y, load_p, load_sp} !== 8'h00 ||
        mem_addr !== 16'h0 || mem_wdata !== 8'h0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs: got req=%b we=%b sp=%b addr=%h wdata=%h data=%h, required all 0",
               mem_req, mem_we, load_sp, mem_addr, mem_wdata, data_out);
    end
    checks++;
    if (mem_model[8'h80] !== 8'hCA || mem_model[8'h7F] !== 8'h00 || exp_mem.size() != 1) begin
      errors++;
      $display("FAIL abort_memory: got m80=%h m7F=%h pending=%0d, required CA 00 1",
               mem_model[8'h80], mem_model[8'h7F], exp_mem.size());
    end
    exp_mem.delete();
    wait_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", cmd_ready); end
    y_in = 16'h0077; sp_in = 16'h0150;
    exp_mem.push_back(mem_t'{1'b1, 16'h0150, 8'h77});
    exp_str.push_back(str_t'{K_SP, 16'h014F});
    do_cmd(1'b0, 2'd2, 1'b0, lat, req1);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL after_abort_latency: got %0d, required 2", lat); end
  endtask

  task automatic test_drained;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_mem.size() != 0 || exp_str.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got mem=%0d strobes=%0d pending, required 0 0", exp_mem.size(), exp_str.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    test_reset;
    test_narrow_push;
    test_wide_push;
    test_wide_pull;
    test_wrap;
    test_wait_states;
    test_snapshot_ignore;
    test_back_to_back;
    test_reset_mid_command;
    test_drained;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
